// File: rtl/mips_pc_pkg.sv
// rtl/mips_pc_pkg.sv - shared types, defaults and helpers for the PC sequencer
//
// Purpose: sequencer state enum, default reset vector and step size, and the
//          target alignment helper used on every loaded (non-sequential) PC.
// Ports:   none (package).

package mips_pc_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } pc_state_e;

  localparam logic [31:0] PC_RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP_DEFAULT         = 4;
  localparam int          PC_ALIGN_BITS_DEFAULT   = 2;

  // Widest address the align helper handles; callers zero-extend into it and
  // truncate the result back to their own width.
  localparam int          PC_MAX_WIDTH            = 64;

  // Clears the low 'bits' address bits of a loaded target.
  function automatic logic [PC_MAX_WIDTH-1:0] pc_align(
    input logic [PC_MAX_WIDTH-1:0] addr,
    input int unsigned             bits
  );
    logic [PC_MAX_WIDTH-1:0] mask;
    mask = {PC_MAX_WIDTH{1'b1}} << bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/pc_redirect_buffer.sv
// rtl/pc_redirect_buffer.sv - holds one redirect that arrived while fetch was stalled
//
// Purpose: single-entry pending redirect register. A capture overwrites any
//          older entry (only the newest redirect matters); clear drops it.
// Ports:
//   Clk            in   clock, posedge
//   Reset          in   synchronous active-high reset, empties the buffer
//   capture        in   load capture_target and mark valid
//   capture_target in   already-aligned redirect target
//   clear          in   invalidate the entry
//   pend_valid     out  an entry is held
//   pend_target    out  held target

module pc_redirect_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             capture,
  input  logic [WIDTH-1:0] capture_target,
  input  logic             clear,
  output logic             pend_valid,
  output logic [WIDTH-1:0] pend_target
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] target_q, target_d;

  always_comb begin
    valid_d  = valid_q;
    target_d = target_q;
    if (Reset) begin
      valid_d  = 1'b0;
      target_d = '0;
    end else if (capture) begin
      valid_d  = 1'b1;
      target_d = capture_target;
    end else if (clear) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    valid_q  <= valid_d;
    target_q <= target_d;
  end

  assign pend_valid  = valid_q;
  assign pend_target = target_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter state and next-PC selection for the BTB-parallel fetch stage
//
// Purpose: owns the fetch PC. Next PC is chosen from, in priority order:
//          reset vector, unstalled EX redirect, buffered redirect, BTB
//          predicted target, sequential PC+STEP. Redirects seen during a
//          stall are buffered and applied the cycle after the stall drops.
//          A halt request parks fetch until the next redirect or reset.
// Ports:
//   Clk              in   clock, posedge
//   Reset            in   synchronous active-high reset
//   PCWrite_Disable  in   stall from hazard unit, 1 holds the PC
//   BtbHit           in   BTB hit (predicted taken) for PCResult
//   BtbTarget        in   predicted target for PCResult
//   Redirect         in   EX-stage mispredict / flush
//   RedirectTarget   in   corrected PC
//   HaltReq          in   stop fetching
//   PCResult         out  current fetch address (registered)
//   PCPlus4          out  PCResult + STEP, wraps
//   FetchValid       out  PCResult is a real fetch this cycle
//   PredTaken        out  next PC comes from BtbTarget
//   Halted           out  sequencer is halted
//   FetchCount       out  saturating count of valid fetches

module pc_sequencer
  import mips_pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR_DEFAULT),
  parameter int               STEP         = PC_STEP_DEFAULT,
  parameter int               ALIGN_BITS   = PC_ALIGN_BITS_DEFAULT,
  parameter int               CNT_WIDTH    = 32
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 PCWrite_Disable,
  input  logic                 BtbHit,
  input  logic [WIDTH-1:0]     BtbTarget,
  input  logic                 Redirect,
  input  logic [WIDTH-1:0]     RedirectTarget,
  input  logic                 HaltReq,
  output logic [WIDTH-1:0]     PCResult,
  output logic [WIDTH-1:0]     PCPlus4,
  output logic                 FetchValid,
  output logic                 PredTaken,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] FetchCount
);

  pc_state_e            state_q, state_d;
  logic [WIDTH-1:0]     pc_q, pc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic                 buf_capture;
  logic                 buf_clear;
  logic                 pend_valid;
  logic [WIDTH-1:0]     pend_target;

  logic [WIDTH-1:0]     redirect_aligned;
  logic [WIDTH-1:0]     btb_aligned;
  logic [WIDTH-1:0]     pc_seq;

  assign redirect_aligned = WIDTH'(pc_align(PC_MAX_WIDTH'(RedirectTarget), ALIGN_BITS));
  assign btb_aligned      = WIDTH'(pc_align(PC_MAX_WIDTH'(BtbTarget), ALIGN_BITS));
  assign pc_seq           = pc_q + WIDTH'(STEP);

  pc_redirect_buffer #(
    .WIDTH(WIDTH)
  ) u_redirect_buffer (
    .Clk           (Clk),
    .Reset         (Reset),
    .capture       (buf_capture),
    .capture_target(redirect_aligned),
    .clear         (buf_clear),
    .pend_valid    (pend_valid),
    .pend_target   (pend_target)
  );

  // State / PC register.
  always_ff @(posedge Clk) begin
    state_q <= state_d;
    pc_q    <= pc_d;
    cnt_q   <= cnt_d;
  end

  // Next-state and next-PC selection; first matching rule wins.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_capture = 1'b0;
    buf_clear   = 1'b0;
    if (Reset) begin
      state_d = RUN;
      pc_d    = RESET_VECTOR;
    end else if (Redirect && !PCWrite_Disable) begin
      // A fresh unstalled redirect supersedes anything buffered or a halt.
      state_d   = RUN;
      pc_d      = redirect_aligned;
      buf_clear = 1'b1;
    end else if (Redirect) begin
      state_d     = PEND;
      buf_capture = 1'b1;
    end else if (PCWrite_Disable) begin
      state_d = state_q;
    end else if (state_q == PEND && pend_valid) begin
      state_d   = RUN;
      pc_d      = pend_target;
      buf_clear = 1'b1;
    end else if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (state_q == RUN && HaltReq) begin
      state_d = HALTED;
    end else if (BtbHit) begin
      pc_d = btb_aligned;
    end else begin
      pc_d = pc_seq;
    end
  end

  // Outputs derived from state and current inputs.
  always_comb begin
    FetchValid = (state_q == RUN) && !PCWrite_Disable;
    PredTaken  = FetchValid && BtbHit && !Redirect;
    Halted     = (state_q == HALTED);
  end

  // Fetch counter sticks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (Reset) begin
      cnt_d = '0;
    end else if (FetchValid && (cnt_q != {CNT_WIDTH{1'b1}})) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  assign PCResult   = pc_q;
  assign PCPlus4    = pc_seq;
  assign FetchCount = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer

module tb_pc_sequencer;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        PCWrite_Disable;
  logic        BtbHit;
  logic [31:0] BtbTarget;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        HaltReq;

  logic [31:0] PCResult, PCPlus4, FetchCount;
  logic        FetchValid, PredTaken, Halted;

  logic [31:0] s_PCResult, s_PCPlus4;
  logic [2:0]  s_FetchCount;
  logic        s_FetchValid, s_PredTaken, s_Halted;

  pc_sequencer dut (
    .Clk(Clk), .Reset(Reset), .PCWrite_Disable(PCWrite_Disable),
    .BtbHit(BtbHit), .BtbTarget(BtbTarget), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .HaltReq(HaltReq),
    .PCResult(PCResult), .PCPlus4(PCPlus4), .FetchValid(FetchValid),
    .PredTaken(PredTaken), .Halted(Halted), .FetchCount(FetchCount)
  );

  pc_sequencer #(.CNT_WIDTH(3)) dut_small (
    .Clk(Clk), .Reset(Reset), .PCWrite_Disable(PCWrite_Disable),
    .BtbHit(BtbHit), .BtbTarget(BtbTarget), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .HaltReq(HaltReq),
    .PCResult(s_PCResult), .PCPlus4(s_PCPlus4), .FetchValid(s_FetchValid),
    .PredTaken(s_PredTaken), .Halted(s_Halted), .FetchCount(s_FetchCount)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        fv;
    logic        pt;
    logic        halted;
    logic [31:0] cnt;
    logic [2:0]  cnt_small;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;

  // Reference model: plain view of the architectural rules.
  logic [31:0]     m_pc;
  bit              m_halted;
  bit              m_pending;
  logic [31:0]     m_pend_addr;
  longint unsigned m_fetches;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return (a >> 2) << 2;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0;
    m_halted    = 1'b0;
    m_pending   = 1'b0;
    m_pend_addr = 32'h0;
    m_fetches   = 0;
  endtask

  // One clock cycle: drive, predict outputs for this cycle, advance the model.
  task automatic step(input bit rst, input bit stall, input bit hit,
                      input logic [31:0] btgt, input bit redir,
                      input logic [31:0] rtgt, input bit halt);
    exp_t e;
    bit   fv;
    Reset           = rst;
    PCWrite_Disable = stall;
    BtbHit          = hit;
    BtbTarget       = btgt;
    Redirect        = redir;
    RedirectTarget  = rtgt;
    HaltReq         = halt;

    fv          = !m_halted && !m_pending && !stall;
    e.pc        = m_pc;
    e.pc4       = m_pc + 32'd4;
    e.fv        = fv;
    e.pt        = fv && hit && !redir;
    e.halted    = m_halted;
    e.cnt       = (m_fetches > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_fetches[31:0];
    e.cnt_small = (m_fetches > 7) ? 3'd7 : m_fetches[2:0];
    exp_q.push_back(e);

    if (rst) begin
      model_reset();
    end else begin
      if (fv) m_fetches++;
      if (redir && !stall) begin
        m_pc      = align4(rtgt);
        m_halted  = 1'b0;
        m_pending = 1'b0;
      end else if (redir) begin
        m_pending   = 1'b1;
        m_pend_addr = align4(rtgt);
        m_halted    = 1'b0;
      end else if (stall) begin
        m_pc = m_pc;
      end else if (m_pending) begin
        m_pc      = m_pend_addr;
        m_pending = 1'b0;
      end else if (m_halted) begin
        m_pc = m_pc;
      end else if (halt) begin
        m_halted = 1'b1;
      end else if (hit) begin
        m_pc = align4(btgt);
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end

    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  // Monitor: compares DUT outputs against the oldest prediction each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("PCResult",   PCResult,             e.pc);
        check("PCPlus4",    PCPlus4,              e.pc4);
        check("FetchValid", {31'b0, FetchValid},  {31'b0, e.fv});
        check("PredTaken",  {31'b0, PredTaken},   {31'b0, e.pt});
        check("Halted",     {31'b0, Halted},      {31'b0, e.halted});
        check("FetchCount", FetchCount,           e.cnt);
        check("FetchCount3", {29'b0, s_FetchCount}, {29'b0, e.cnt_small});
        check("PCResult_small", s_PCResult,       e.pc);
      end
    end
  end

  initial begin
    Reset = 1'b1; PCWrite_Disable = 1'b0; BtbHit = 1'b0; BtbTarget = 32'h0;
    Redirect = 1'b0; RedirectTarget = 32'h0; HaltReq = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();

    // Sequential fetch from reset, then BTB prediction at 0x8.
    idle(2);
    step(0, 0, 1, 32'h43, 0, 32'h0, 0);
    // Redirect beats a simultaneous BTB hit.
    step(0, 0, 1, 32'h99, 1, 32'hC, 0);
    idle(1);

    // Redirects during a stall at 0x10; newest wins.
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step(0, 1, 0, 32'h0, 1, 32'h100, 0);
    step(0, 1, 0, 32'h0, 1, 32'h200, 0);
    step(0, 0, 1, 32'h500, 0, 32'h0, 1);
    idle(2);

    // Halt at 0x20, stay parked, then leave via redirect.
    step(0, 0, 0, 32'h0, 1, 32'h20, 0);
    step(0, 0, 0, 32'h0, 0, 32'h0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h700, 0, 32'h0, i[0]);
    step(0, 0, 0, 32'h0, 1, 32'h82, 0);
    idle(2);

    // Reset while pending and stalled discards the pending target.
    step(0, 1, 0, 32'h0, 1, 32'h300, 0);
    step(0, 1, 0, 32'h0, 0, 32'h0, 0);
    step(1, 1, 0, 32'h0, 0, 32'h0, 0);
    idle(3);

    // PC wraps at the top of the address space; small counter saturates.
    step(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFE, 0);
    idle(12);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(63) == 0, $urandom_range(3) == 0, $urandom_range(2) == 0,
           $urandom(), $urandom_range(7) == 0, $urandom(), $urandom_range(15) == 0);
    end

    idle(1);
    repeat (3) @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending predictions expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
